// File: rtl/frost32_mem_access_ctrl_pkg.sv
// Shared types for the Frost32 memory access controller: CPU access encodings
// and the controller state machine.
package frost32_mem_access_ctrl_pkg;

    typedef enum logic {
        DiatRead  = 1'b0,
        DiatWrite = 1'b1
    } DataInoutAccessType;

    typedef enum logic [1:0] {
        Dias32  = 2'd0,
        Dias16  = 2'd1,
        Dias8   = 2'd2,
        DiasBad = 2'd3
    } DataInoutAccessSize;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } MemCtrlState;

    // Wide enough to hold the largest supported read latency (4).
    localparam int MemCtrlCountWidth = 3;

endpackage

// File: rtl/frost32_mem_access_ctrl_if.sv
// CPU-side request/response signals and RAM-side strobes of the memory access
// controller, bundled so the controller and its environment share one port.
interface frost32_mem_access_ctrl_if #(
    parameter int MEM_ADDR_WIDTH = 14
);
    import frost32_mem_access_ctrl_pkg::*;

    logic                      cpu_req;
    logic [31:0]               cpu_addr;
    logic [31:0]               cpu_wdata;
    DataInoutAccessType        cpu_access_type;
    DataInoutAccessSize        cpu_access_size;
    logic [31:0]               cpu_rdata;
    logic                      cpu_wait_for_mem;
    logic                      cpu_access_fault;
    logic                      mem_en;
    logic                      mem_we;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]               mem_wdata;
    logic [3:0]                mem_byte_en;
    logic [31:0]               mem_rdata;

    // The CPU together with the RAM form the environment around the controller.
    modport master (
        output cpu_req, cpu_addr, cpu_wdata, cpu_access_type, cpu_access_size, mem_rdata,
        input  cpu_rdata, cpu_wait_for_mem, cpu_access_fault,
               mem_en, mem_we, mem_addr, mem_wdata, mem_byte_en
    );

    modport slave (
        input  cpu_req, cpu_addr, cpu_wdata, cpu_access_type, cpu_access_size, mem_rdata,
        output cpu_rdata, cpu_wait_for_mem, cpu_access_fault,
               mem_en, mem_we, mem_addr, mem_wdata, mem_byte_en
    );

endinterface

// File: rtl/frost32_mem_lane_steer.sv
// Combinational byte-lane steering between a 32-bit little-endian RAM word and
// right-justified CPU data, plus the alignment check for each access size.
module frost32_mem_lane_steer
    import frost32_mem_access_ctrl_pkg::*;
(
    input  DataInoutAccessSize size_i,
    input  logic [1:0]         lane_i,
    input  logic [31:0]        wdata_i,
    input  logic [31:0]        rdata_i,
    output logic [31:0]        wdata_o,
    output logic [3:0]         byteEn_o,
    output logic [31:0]        rdata_o,
    output logic               misaligned_o
);

    logic [31:0] shiftedRdata;

    always_comb begin
        wdata_o      = '0;
        byteEn_o     = '0;
        rdata_o      = '0;
        misaligned_o = 1'b1;
        shiftedRdata = rdata_i >> {lane_i, 3'b000};
        case (size_i)
            Dias32: begin
                wdata_o      = wdata_i;
                byteEn_o     = 4'b1111;
                rdata_o      = rdata_i;
                misaligned_o = (lane_i != 2'b00);
            end
            Dias16: begin
                wdata_o      = {2{wdata_i[15:0]}};
                byteEn_o     = lane_i[1] ? 4'b1100 : 4'b0011;
                rdata_o      = {16'h0000, shiftedRdata[15:0]};
                misaligned_o = lane_i[0];
            end
            Dias8: begin
                wdata_o      = {4{wdata_i[7:0]}};
                byteEn_o     = 4'b0001 << lane_i;
                rdata_o      = {24'h000000, shiftedRdata[7:0]};
                misaligned_o = 1'b0;
            end
            default: begin
                misaligned_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/frost32_mem_access_ctrl.sv
// Bridges the Frost32 CPU memory port to a synchronous word-addressed RAM with
// byte enables: one RAM strobe per access, lane steering and a fixed read latency.
module frost32_mem_access_ctrl
    import frost32_mem_access_ctrl_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH   = 14,
    parameter int MEM_READ_LATENCY = 1
) (
    input logic                    clk,
    input logic                    rst_n,
    frost32_mem_access_ctrl_if.slave bus
);

    localparam logic [MemCtrlCountWidth-1:0] LatencyLoad = MemCtrlCountWidth'(MEM_READ_LATENCY);

    MemCtrlState                   state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0]     addrWord_q, addrWord_d;
    logic [1:0]                    lane_q, lane_d;
    DataInoutAccessSize            size_q, size_d;
    logic                          isWrite_q, isWrite_d;
    logic                          fault_q, fault_d;
    logic [31:0]                   wdata_q, wdata_d;
    logic [3:0]                    byteEn_q, byteEn_d;
    logic [31:0]                   rdata_q, rdata_d;
    logic [MemCtrlCountWidth-1:0]  count_q, count_d;

    DataInoutAccessSize            steerSize;
    logic [1:0]                    steerLane;
    logic [31:0]                   steerWdata;
    logic [3:0]                    steerByteEn;
    logic [31:0]                   steerRdata;
    logic                          steerMisaligned;

    // While idle the steering sees the incoming request so its write lanes and
    // fault check can be captured; afterwards it sees the latched access for reads.
    assign steerSize = (state_q == StIdle) ? bus.cpu_access_size : size_q;
    assign steerLane = (state_q == StIdle) ? bus.cpu_addr[1:0]   : lane_q;

    frost32_mem_lane_steer u_lane_steer (
        .size_i       (steerSize),
        .lane_i       (steerLane),
        .wdata_i      (bus.cpu_wdata),
        .rdata_i      (bus.mem_rdata),
        .wdata_o      (steerWdata),
        .byteEn_o     (steerByteEn),
        .rdata_o      (steerRdata),
        .misaligned_o (steerMisaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addrWord_q <= '0;
            lane_q     <= '0;
            size_q     <= Dias32;
            isWrite_q  <= 1'b0;
            fault_q    <= 1'b0;
            wdata_q    <= '0;
            byteEn_q   <= '0;
            rdata_q    <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            addrWord_q <= addrWord_d;
            lane_q     <= lane_d;
            size_q     <= size_d;
            isWrite_q  <= isWrite_d;
            fault_q    <= fault_d;
            wdata_q    <= wdata_d;
            byteEn_q   <= byteEn_d;
            rdata_q    <= rdata_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addrWord_d = addrWord_q;
        lane_d     = lane_q;
        size_d     = size_q;
        isWrite_d  = isWrite_q;
        fault_d    = fault_q;
        wdata_d    = wdata_q;
        byteEn_d   = byteEn_q;
        rdata_d    = rdata_q;
        count_d    = count_q;
        case (state_q)
            StIdle: begin
                if (bus.cpu_req) begin
                    addrWord_d = bus.cpu_addr[MEM_ADDR_WIDTH+1:2];
                    lane_d     = bus.cpu_addr[1:0];
                    size_d     = bus.cpu_access_size;
                    isWrite_d  = (bus.cpu_access_type == DiatWrite);
                    fault_d    = steerMisaligned;
                    wdata_d    = steerWdata;
                    byteEn_d   = steerByteEn;
                    rdata_d    = '0;
                    state_d    = steerMisaligned ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (isWrite_q) begin
                    state_d = StDone;
                end else begin
                    count_d = LatencyLoad;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (count_q == MemCtrlCountWidth'(1)) begin
                    rdata_d = steerRdata;
                    state_d = StDone;
                end else begin
                    count_d = count_q - MemCtrlCountWidth'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Strobes decode straight from the state so an asynchronous reset kills them at once.
    assign bus.mem_en           = (state_q == StIssue);
    assign bus.mem_we           = (state_q == StIssue) && isWrite_q;
    assign bus.mem_addr         = addrWord_q;
    assign bus.mem_wdata        = wdata_q;
    assign bus.mem_byte_en      = byteEn_q;
    assign bus.cpu_rdata        = rdata_q;
    assign bus.cpu_access_fault = (state_q == StDone) && fault_q;
    assign bus.cpu_wait_for_mem = rst_n && (((state_q == StIdle) && bus.cpu_req) ||
                                            (state_q == StIssue) || (state_q == StWait));

endmodule
